fpu_dest_tracker: RTL

Destination-tag pipeline for the FPU. It records the destination FPR index, write-enable and latency of every issued FPU operation and shifts them through six in-flight stages in lock-step with the FPU datapath. It drives the per-stage `rdi_buf_k` / `legal_k` tags consumed by the FPU forwarding-select logic, the `busy_k` tags used by issue-stall logic, and the FPR writeback strobe. It sits between FPU issue/decode and the forwarding comparators.

---
 rtl/fpu_dest_tracker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fpu_dest_tracker.sv
// fpu_dest_tracker
//   Destination-tag pipeline for the FPU. Every issued op's destination FPR,
//   write-enable and result latency move through six in-flight stages in
//   lock-step with the FPU datapath. From these stages the block drives the
//   per-stage forwarding tags, the issue-stall busy tags, the FPR writeback
//   strobe and an in-flight op count.
//
// Ports
//   clk                    clock, all state changes on the rising edge
//   rstn                   synchronous active-low reset
//   issue_valid            an FPU op issues this cycle
//   issue_rd               destination FPR of the issuing op
//   issue_wen              issuing op writes an FPR
//   issue_lat              result latency in stages (0 -> 1, 7 -> 6)
//   stall                  pipeline freeze, all stages hold
//   flush                  kill every in-flight op
//   rdi_buf_1..6           destination tag held in stage k
//   legal_1..6             stage k result is computed and forwardable
//   busy_1..6              stage k result is still being computed
//   wb_valid / wb_rd       FPR write strobe and its destination
//   inflight               number of valid stages, 0..6
module fpu_dest_tracker #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_wen,
  input  logic [2:0]       issue_lat,
  input  logic             stall,
  input  logic             flush,
  output logic [REG_W-1:0] rdi_buf_1,
  output logic [REG_W-1:0] rdi_buf_2,
  output logic [REG_W-1:0] rdi_buf_3,
  output logic [REG_W-1:0] rdi_buf_4,
  output logic [REG_W-1:0] rdi_buf_5,
  output logic [REG_W-1:0] rdi_buf_6,
  output logic             legal_1,
  output logic             legal_2,
  output logic             legal_3,
  output logic             legal_4,
  output logic             legal_5,
  output logic             legal_6,
  output logic             busy_1,
  output logic             busy_2,
  output logic             busy_3,
  output logic             busy_4,
  output logic             busy_5,
  output logic             busy_6,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [2:0]       inflight
);

  logic [6:1]       v;
  logic [6:1]       wen;
  logic [REG_W-1:0] rd  [1:6];
  logic [2:0]       lat [1:6];
  logic [2:0]       cnt;
  logic [6:1]       legal;
  logic [6:1]       busy;

  // Latencies outside 1..6 are folded onto the nearest legal value.
  function automatic logic [2:0] clamp_lat(input logic [2:0] l);
    logic [2:0] r;
    r = l;
    if (l == 3'd0) r = 3'd1;
    if (l == 3'd7) r = 3'd6;
    return r;
  endfunction

  // Stage 1..6 registers: reset/flush clears everything, stall holds.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      v   <= '0;
      wen <= '0;
      for (int k = 1; k <= 6; k++) begin
        rd[k]  <= '0;
        lat[k] <= '0;
      end
      cnt <= '0;
    end else if (!stall) begin
      v[1]   <= issue_valid;
      wen[1] <= issue_wen;
      rd[1]  <= issue_rd;
      lat[1] <= clamp_lat(issue_lat);
      for (int k = 2; k <= 6; k++) begin
        v[k]   <= v[k-1];
        wen[k] <= wen[k-1];
        rd[k]  <= rd[k-1];
        lat[k] <= lat[k-1];
      end
      // Entry and retire in the same cycle cancel out.
      if (issue_valid && !v[6])
        cnt <= cnt + 3'd1;
      else if (!issue_valid && v[6])
        cnt <= cnt - 3'd1;
    end
  end

  // A writing op is busy before its latency stage and legal from it onward.
  always_comb begin
    legal = '0;
    busy  = '0;
    for (int k = 1; k <= 6; k++) begin
      legal[k] = v[k] & wen[k] & (3'(k) >= lat[k]);
      busy[k]  = v[k] & wen[k] & (3'(k) <  lat[k]);
    end
  end

  assign rdi_buf_1 = rd[1];
  assign rdi_buf_2 = rd[2];
  assign rdi_buf_3 = rd[3];
  assign rdi_buf_4 = rd[4];
  assign rdi_buf_5 = rd[5];
  assign rdi_buf_6 = rd[6];

  assign legal_1 = legal[1];
  assign legal_2 = legal[2];
  assign legal_3 = legal[3];
  assign legal_4 = legal[4];
  assign legal_5 = legal[5];
  assign legal_6 = legal[6];

  assign busy_1 = busy[1];
  assign busy_2 = busy[2];
  assign busy_3 = busy[3];
  assign busy_4 = busy[4];
  assign busy_5 = busy[5];
  assign busy_6 = busy[6];

  // The stage-6 op only writes on the cycle it actually leaves, so a stall
  // defers the strobe rather than repeating it.
  assign wb_valid = v[6] & wen[6] & ~stall & ~flush;
  assign wb_rd    = rd[6];
  assign inflight = cnt;

endmodule
